// File: rtl/fir_mac_engine.sv
// fir_mac_engine
//   Sequential FIR stage. It has one multiplier and a TAPS-deep sample
//   delay line. Each accepted sample takes TAPS clocks, one tap per clock.
//   The accumulator is shifted right arithmetically by SHIFT and then
//   saturated to DATA_W bits. The result goes out with a one-cycle
//   out_valid pulse.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   sample present on in_data
//   in_data    signed input sample (DATA_W)
//   in_ready   engine idle, so a sample is taken this cycle
//   coef_we    coefficient write strobe (honoured only while idle)
//   coef_addr  tap index to write
//   coef_data  signed coefficient (COEF_W, SHIFT fraction bits)
//   out_valid  one-cycle pulse marking a new out_data
//   out_data   signed saturated result; holds until the next result
module fir_mac_engine #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 4,
  parameter int SHIFT  = 6,
  localparam int ADDR_W = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  input  logic                     coef_we,
  input  logic [ADDR_W-1:0]        coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);

  typedef enum logic {IDLE, MAC} state_t;

  state_t                   state;
  logic signed [DATA_W-1:0] x [TAPS];
  logic signed [COEF_W-1:0] c [TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic [ADDR_W-1:0]        idx;

  logic                     accept;
  logic                     coef_wr;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  acc_shr;
  logic signed [ACC_W-1:0]  sat_max;
  logic signed [ACC_W-1:0]  sat_min;
  logic signed [DATA_W-1:0] sat_val;

  assign in_ready = (state == IDLE);
  assign accept   = in_ready && in_valid;
  // Addresses past the last tap are dropped. The compare is done in int
  // width so that it also works when TAPS is not a power of two.
  assign coef_wr  = in_ready && coef_we && (int'(coef_addr) < TAPS);

  assign sat_max = ACC_W'(2 ** (DATA_W - 1) - 1);
  assign sat_min = ACC_W'(-(2 ** (DATA_W - 1)));

  always_comb begin
    // Both operands are sign-extended to the product width before the
    // multiply, so the low PROD_W bits hold the exact signed product.
    prod     = PROD_W'(x[idx]) * PROD_W'(c[idx]);
    prod_ext = $signed({{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod});
    // acc_sum already includes the current tap's product. On the final MAC
    // edge, the saturated output is taken from this value.
    acc_sum  = acc + prod_ext;
    acc_shr  = acc_sum >>> SHIFT;
    if (acc_shr > sat_max) begin
      sat_val = sat_max[DATA_W-1:0];
    end else if (acc_shr < sat_min) begin
      sat_val = sat_min[DATA_W-1:0];
    end else begin
      sat_val = acc_shr[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int k = 0; k < TAPS; k++) begin
        x[k] <= '0;
        c[k] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      // A write on the accept edge lands before the first MAC edge, so the
      // computation that starts on that edge uses the new coefficient.
      if (coef_wr) begin
        c[coef_addr] <= coef_data;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            x[0] <= in_data;
            for (int k = 1; k < TAPS; k++) begin
              x[k] <= x[k-1];
            end
            acc   <= '0;
            idx   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc_sum;
          idx <= idx + ADDR_W'(1);
          if (idx == ADDR_W'(TAPS - 1)) begin
            out_data  <= sat_val;
            out_valid <= 1'b1;
            idx       <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_engine.sv
module tb_fir_mac_engine;
  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int TAPS   = 4;
  localparam int SHIFT  = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              coef_we = 1'b0;
  logic [1:0]        coef_addr = '0;
  logic [COEF_W-1:0] coef_data = '0;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: a plain array history of samples and coefficients.
  int coef_m [TAPS];
  int hist_m [TAPS];

  typedef struct {
    bit rst_first;
    int c0, c1, c2, c3;
    int sample;
    int exp_out;
  } vec_t;
  vec_t vecs [16];

  always #5 clk = ~clk;

  fir_mac_engine #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid), .out_data(out_data)
  );

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int sx(input logic [DATA_W-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic int model_result();
    int sum = 0;
    int q;
    int hi = (1 << (DATA_W - 1)) - 1;
    int lo = -(1 << (DATA_W - 1));
    for (int k = 0; k < TAPS; k++) sum += hist_m[k] * coef_m[k];
    q = sum >>> SHIFT;
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    return q;
  endfunction

  task automatic model_push(input int v);
    for (int k = TAPS - 1; k > 0; k--) hist_m[k] = hist_m[k-1];
    hist_m[0] = v;
  endtask

  task automatic model_clear();
    for (int k = 0; k < TAPS; k++) begin
      coef_m[k] = 0;
      hist_m[k] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset is raised between clock edges. The outputs must clear before the next edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", sx(out_data), 0);
    check("rst_in_ready", in_ready, 1);
    tick();
    rst = 1'b0;
    model_clear();
  endtask

  task automatic write_coef(input int a, input int d);
    logic [31:0] dv;
    dv = d;
    coef_addr = a[1:0];
    coef_data = dv[COEF_W-1:0];
    coef_we = 1'b1;
    tick();
    coef_we = 1'b0;
    coef_m[a] = sx(dv[COEF_W-1:0]);
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!in_ready) check("ready_timeout", 0, 1);
  endtask

  task automatic count_pulses(input int n, output int p);
    p = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (out_valid) p++;
    end
  endtask

  // One full transaction. It checks latency, the busy window and the
  // pulse width, and returns the result.
  task automatic send(input int v, output int res);
    int busy, lat, held;
    logic [31:0] vv;
    vv = v;
    wait_ready();
    in_valid = 1'b1;
    in_data = vv[DATA_W-1:0];
    tick();
    in_valid = 1'b0;
    model_push(sx(vv[DATA_W-1:0]));
    busy = 0;
    lat = 0;
    while (lat < 3 * TAPS && !out_valid) begin
      if (!in_ready) busy++;
      tick();
      lat++;
    end
    check("latency", lat, TAPS);
    check("busy_cycles", busy, TAPS);
    check("ready_on_out", in_ready, 1);
    res = sx(out_data);
    held = res;
    tick();
    check("pulse_width", out_valid, 0);
    check("out_hold", sx(out_data), held);
  endtask

  initial begin
    int res, p, got, cyc, last;

    vecs[0]  = '{1'b1, 64, 0, 0, 0, 25, 25};
    vecs[1]  = '{1'b1, 64, 0, 0, 0, -5, -5};
    vecs[2]  = '{1'b1, 16, 16, 16, 16, 40, 10};
    vecs[3]  = '{1'b0, 16, 16, 16, 16, 40, 20};
    vecs[4]  = '{1'b0, 16, 16, 16, 16, 40, 30};
    vecs[5]  = '{1'b0, 16, 16, 16, 16, 40, 40};
    vecs[6]  = '{1'b1, 127, 127, 127, 127, 127, 127};
    vecs[7]  = '{1'b0, 127, 127, 127, 127, 127, 127};
    vecs[8]  = '{1'b0, 127, 127, 127, 127, 127, 127};
    vecs[9]  = '{1'b0, 127, 127, 127, 127, 127, 127};
    vecs[10] = '{1'b0, 127, 127, 127, 127, -128, 127};
    vecs[11] = '{1'b0, 127, 127, 127, 127, -128, -4};
    vecs[12] = '{1'b0, 127, 127, 127, 127, -128, -128};
    vecs[13] = '{1'b0, 127, 127, 127, 127, -128, -128};
    vecs[14] = '{1'b1, 32, -32, 0, 0, 10, 5};
    vecs[15] = '{1'b0, 32, -32, 0, 0, 3, -4};

    model_clear();
    tick();
    do_reset();

    // Table vectors
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].rst_first) do_reset();
      write_coef(0, vecs[i].c0);
      write_coef(1, vecs[i].c1);
      write_coef(2, vecs[i].c2);
      write_coef(3, vecs[i].c3);
      send(vecs[i].sample, res);
      check($sformatf("vec%0d", i), res, vecs[i].exp_out);
      $display("vec %0d sample %0d out %0d", i, vecs[i].sample, res);
    end

    // Reset raised mid-cycle during MAC: outputs clear at once, no pulse follows
    in_valid = 1'b1;
    in_data = 8'd50;
    tick();
    in_valid = 1'b0;
    tick();
    do_reset();
    count_pulses(2 * TAPS, p);
    check("no_pulse_after_rst", p, 0);
    $display("async reset mid-MAC pulses %0d", p);

    // Back-to-back: in_valid held high, each sample is taken in the out_valid cycle
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, 16);
    in_valid = 1'b1;
    in_data = 8'd40;
    got = 0;
    cyc = 0;
    last = -1;
    while (got < 4 && cyc < 60) begin
      tick();
      cyc++;
      if (out_valid) begin
        got++;
        check("b2b_data", sx(out_data), 10 * got);
        check("b2b_ready", in_ready, 1);
        if (last >= 0) check("b2b_period", cyc - last, TAPS + 1);
        last = cyc;
        if (got == 4) in_valid = 1'b0;
        $display("b2b result %0d out %0d cycle %0d", got, sx(out_data), cyc);
      end
    end
    in_valid = 1'b0;
    check("b2b_count", got, 4);

    // in_valid and coef_we during MAC are ignored; a coef write on the accept edge is used
    do_reset();
    write_coef(0, 64);
    in_valid = 1'b1;
    in_data = 8'd25;
    tick();
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1;
    in_data = 8'd99;
    coef_we = 1'b1;
    coef_addr = 2'd0;
    coef_data = 8'd0;
    tick();
    tick();
    in_valid = 1'b0;
    coef_we = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 3 * TAPS) begin
      tick();
      cyc++;
    end
    check("mac_ignore_out_valid", out_valid, 1);
    check("mac_ignore_data", sx(out_data), 25);
    $display("mac-ignore out %0d", sx(out_data));
    tick();
    coef_we = 1'b1;
    coef_addr = 2'd1;
    coef_data = 8'd64;
    in_valid = 1'b1;
    in_data = 8'd9;
    tick();
    coef_we = 1'b0;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 3 * TAPS) begin
      tick();
      cyc++;
    end
    check("same_edge_coef", sx(out_data), 34);
    $display("same-edge coef write out %0d", sx(out_data));

    // Reset on edge E2 of a computation, then the delay line must be empty
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, 16);
    send(50, res);
    check("pre_rst_result", res, 12);
    in_valid = 1'b1;
    in_data = 8'd60;
    tick();
    in_valid = 1'b0;
    tick();
    @(posedge clk);
    rst = 1'b1;
    #1;
    check("e2_rst_out_valid", out_valid, 0);
    check("e2_rst_in_ready", in_ready, 1);
    tick();
    rst = 1'b0;
    model_clear();
    count_pulses(2 * TAPS, p);
    check("e2_no_pulse", p, 0);
    for (int k = 0; k < TAPS; k++) write_coef(k, 64);
    send(7, res);
    check("dline_cleared", res, 7);
    $display("after E2 reset send 7 out %0d", res);

    // Random samples and coefficients against the reference model
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, int'($urandom_range(0, 255)) - 128);
    for (int i = 0; i < 40; i++) begin
      int s;
      if ($urandom_range(0, 2) == 0)
        write_coef(int'($urandom_range(0, TAPS - 1)), int'($urandom_range(0, 255)) - 128);
      s = int'($urandom_range(0, 255)) - 128;
      send(s, res);
      check($sformatf("rand%0d", i), res, model_result());
      $display("rand %0d sample %0d out %0d model %0d", i, s, res, model_result());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
